regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources.

---
 rtl/regfile_ctrl_pkg.sv | 19 +
 rtl/wb_scoreboard.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file writeback arbiter and its scoreboard.
package regfile_ctrl_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write busy bits: set at issue, cleared by a committed writeback.
module wb_scoreboard
  import regfile_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic [ADDR_W-1:0] q1_reg,
  input  logic [ADDR_W-1:0] q2_reg,
  output logic              q1_busy,
  output logic              q2_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Clear applied first so a same-cycle set of the same register wins; r0 never goes busy.
  always_comb begin
    busy_next = busy;
    if (clr) begin
      busy_next[clr_reg] = 1'b0;
    end
    if (set && (set_reg != '0)) begin
      busy_next[set_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign q1_busy = busy[q1_reg];
  assign q2_busy = busy[q2_reg];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file write port (A priority, B anti-starvation).
// Optional scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              regWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] writeData,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_set_reg,
  input  logic [ADDR_W-1:0] q1_reg,
  input  logic [ADDR_W-1:0] q2_reg,
  output logic              q1_busy,
  output logic              q2_busy
);

  localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state;
  arb_state_e       state_next;
  grant_e           grant_c;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PRIO_A;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Promotion looks at the updated count so B wins exactly on the stall after the limit.
  always_comb begin
    state_next  = state;
    grant_c     = GNT_NONE;
    starve_next = '0;
    if (rst) begin
      unique case (state)
        PRIO_A: begin
          if (a_valid)      grant_c = GNT_A;
          else if (b_valid) grant_c = GNT_B;
        end
        PRIO_B: begin
          if (b_valid)      grant_c = GNT_B;
          else if (a_valid) grant_c = GNT_A;
        end
        default: grant_c = GNT_NONE;
      endcase

      if (b_valid && (grant_c != GNT_B)) begin
        starve_next = (starve_cnt == CNT_MAX) ? CNT_MAX : CNT_W'(starve_cnt + 1'b1);
      end

      unique case (state)
        PRIO_A: if (starve_next == CNT_MAX) state_next = PRIO_B;
        PRIO_B: if ((grant_c == GNT_B) || !b_valid) state_next = PRIO_A;
        default: state_next = PRIO_A;
      endcase
    end
  end

  assign a_ready = (grant_c == GNT_A);
  assign b_ready = (grant_c == GNT_B);

  // Writes to r0 are consumed but never enabled; index/data still track the winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWrite  <= 1'b0;
      WriteReg  <= '0;
      writeData <= '0;
    end else begin
      unique case (grant_c)
        GNT_A: begin
          regWrite  <= (a_reg != '0);
          WriteReg  <= a_reg;
          writeData <= a_data;
        end
        GNT_B: begin
          regWrite  <= (b_reg != '0);
          WriteReg  <= b_reg;
          writeData <= b_data;
        end
        default: regWrite <= 1'b0;
      endcase
    end
  end

`ifdef WB_SCOREBOARD_EN
  wb_scoreboard u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set     (sb_set),
    .set_reg (sb_set_reg),
    .clr     (regWrite),
    .clr_reg (WriteReg),
    .q1_reg  (q1_reg),
    .q2_reg  (q2_reg),
    .q1_busy (q1_busy),
    .q2_busy (q2_busy)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_set_reg, q1_reg, q2_reg};
  assign q1_busy   = 1'b0;
  assign q2_busy   = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a history-based reference model.
module tb_regfile_wb_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int unsigned LIMIT = 4;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [ADDR_W-1:0] a_reg, b_reg, WriteReg, sb_set_reg, q1_reg, q2_reg;
  logic [DATA_W-1:0] a_data, b_data, writeData;
  logic              regWrite, sb_set, q1_busy, q2_busy;

  int checks = 0;
  int failures = 0;

  // Reference model: grant rule from stall history, one-deep write pipe, busy set.
  int                stall_run;
  logic              m_we;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  logic [NUM_REGS-1:0] m_busy;
  int                last_gnt;
  logic              obs_a_ready, obs_b_ready, obs_we, obs_q1;
  logic [ADDR_W-1:0] obs_reg;
  logic [DATA_W-1:0] obs_data;
  bit                a_pend, b_pend;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
    .regWrite(regWrite), .WriteReg(WriteReg), .writeData(writeData),
    .sb_set(sb_set), .sb_set_reg(sb_set_reg),
    .q1_reg(q1_reg), .q2_reg(q2_reg), .q1_busy(q1_busy), .q2_busy(q2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (!rst) return 0;
    if (b_valid && ((stall_run >= int'(LIMIT)) || !a_valid)) return 2;
    if (a_valid) return 1;
    return 0;
  endfunction

  task automatic reset_model();
    stall_run = 0;
    m_we      = 1'b0;
    m_reg     = '0;
    m_data    = '0;
    m_busy    = '0;
  endtask

  // One clock: check at negedge, then advance the model across the posedge.
  task automatic cycle();
    int g;
    @(negedge clk);
    if (!rst) reset_model();
    g = exp_grant();
    obs_a_ready = a_ready;
    obs_b_ready = b_ready;
    obs_we      = regWrite;
    obs_reg     = WriteReg;
    obs_data    = writeData;
    obs_q1      = q1_busy;
    chk("a_ready", 32'(a_ready), 32'(g == 1));
    chk("b_ready", 32'(b_ready), 32'(g == 2));
    chk("regWrite", 32'(regWrite), 32'(m_we));
    chk("WriteReg", 32'(WriteReg), 32'(m_reg));
    chk("writeData", writeData, m_data);
    chk("q1_busy", 32'(q1_busy), 32'(SB_EN ? m_busy[q1_reg] : 1'b0));
    chk("q2_busy", 32'(q2_busy), 32'(SB_EN ? m_busy[q2_reg] : 1'b0));
    last_gnt = g;
    @(posedge clk);
    if (rst) begin
      if (m_we) m_busy[m_reg] = 1'b0;
      if (sb_set && (sb_set_reg != '0)) m_busy[sb_set_reg] = 1'b1;
      stall_run = (b_valid && (g != 2)) ? stall_run + 1 : 0;
      if (g == 1) begin
        m_we = (a_reg != '0); m_reg = a_reg; m_data = a_data;
      end else if (g == 2) begin
        m_we = (b_reg != '0); m_reg = b_reg; m_data = b_data;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; b_valid = 1'b0; sb_set = 1'b0;
  endtask

  initial begin
    rst = 1'b0; idle();
    a_reg = '0; a_data = '0; b_reg = '0; b_data = '0;
    sb_set_reg = '0; q1_reg = '0; q2_reg = '0;
    reset_model();
    last_gnt = 0;

    // Reset with A requesting: no grant, no write.
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'hAB;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_a_ready", 32'(obs_a_ready), 32'd0);
      chk("rst_regWrite", 32'(obs_we), 32'd0);
    end
    rst = 1'b1;
    cycle();
    chk("rel_grant", 32'(obs_a_ready), 32'd1);
    a_valid = 1'b0;
    cycle();
    chk("rel_write_we", 32'(obs_we), 32'd1);
    chk("rel_write_reg", 32'(obs_reg), 32'd5);

    // Both valid, A wins for three cycles, then B.
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("ab_a_wins", 32'(obs_a_ready), 32'd1);
      if (i > 0) chk("ab_write_reg", 32'(obs_reg), 32'd3);
    end
    a_valid = 1'b0;
    cycle();
    chk("ab_b_after", 32'(obs_b_ready), 32'd1);
    chk("ab_a_data", obs_data, 32'h11);
    b_valid = 1'b0;
    cycle();
    chk("ab_b_reg", 32'(obs_reg), 32'd4);
    chk("ab_b_data", obs_data, 32'h22);

    // Starvation promotion: B wins every fifth cycle.
    a_valid = 1'b1; a_reg = 5'd1; a_data = 32'hA1;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'hB2;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("starve_b", 32'(obs_b_ready), 32'((i % 5) == 4));
      chk("starve_a", 32'(obs_a_ready), 32'((i % 5) != 4));
    end

    // Register 0 is consumed without a write enable.
    idle();
    cycle();
    a_valid = 1'b1; a_reg = '0; a_data = 32'hFFFF_FFFF;
    cycle();
    chk("r0_ready", 32'(obs_a_ready), 32'd1);
    a_valid = 1'b0;
    cycle();
    chk("r0_we", 32'(obs_we), 32'd0);
    chk("r0_data", obs_data, 32'hFFFF_FFFF);

    // Scoreboard set, clear by commit, and same-cycle set/clear.
    sb_set = 1'b1; sb_set_reg = 5'd7; q1_reg = 5'd7;
    cycle();
    sb_set = 1'b0;
    cycle();
    chk("sb_set_busy", 32'(obs_q1), 32'(SB_EN));
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h77;
    cycle();
    b_valid = 1'b0;
    cycle();
    chk("sb_commit_we", 32'(obs_we), 32'd1);
    chk("sb_still_busy", 32'(obs_q1), 32'(SB_EN));
    cycle();
    chk("sb_cleared", 32'(obs_q1), 32'd0);
    b_valid = 1'b1;
    cycle();
    b_valid = 1'b0; sb_set = 1'b1;
    cycle();
    chk("sb_clr_same_we", 32'(obs_we), 32'd1);
    sb_set = 1'b0;
    cycle();
    chk("sb_set_wins", 32'(obs_q1), 32'(SB_EN));

    // Randomized traffic honouring the hold-until-ready handshake, with a mid-run reset.
    idle();
    cycle();
    a_pend = 1'b0; b_pend = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (last_gnt == 1) a_pend = 1'b0;
      if (last_gnt == 2) b_pend = 1'b0;
      if (!a_pend && ($urandom_range(99) < 60)) begin
        a_pend = 1'b1; a_reg = ADDR_W'($urandom_range(7)); a_data = $urandom();
      end
      if (!b_pend && ($urandom_range(99) < 50)) begin
        b_pend = 1'b1; b_reg = ADDR_W'($urandom_range(7)); b_data = $urandom();
      end
      a_valid    = a_pend;
      b_valid    = b_pend;
      sb_set     = ($urandom_range(3) == 0);
      sb_set_reg = ADDR_W'($urandom_range(7));
      q1_reg     = ADDR_W'($urandom_range(7));
      q2_reg     = ADDR_W'($urandom_range(7));
      rst        = !((i == 150) || (i == 151));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
